// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: tag width, controller state
// encoding and the writeback-tracking entry held per in-flight stage.
package pipe_ctrl_pkg;

    localparam int TAG_W = 6;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        tag_t rd;
        logic is_load;
    } sb_entry_t;

    // A source only conflicts when it is actually read and is not the
    // hard-wired zero register.
    function automatic logic tag_hit(input tag_t src, input logic used, input tag_t rd);
        return used && (src != '0) && (src == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_scoreboard.sv
// Writeback scoreboard: one entry per in-flight stage (entry 0 = EX,
// last entry = WB). Shifts on advance and flags ID read-after-write hazards.
// Build option PIPE_CTRL_FWD_EN: with forwarding only a load sitting in EX
// can hazard; without it every valid in-flight writer hazards.
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int WB_DEPTH = 3
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      advance,
    input  sb_entry_t push_entry,
    input  logic      id_valid,
    input  tag_t      id_rs,
    input  tag_t      id_rt,
    input  logic      id_rs_used,
    input  logic      id_rt_used,
    output logic      hazard
);

    sb_entry_t sb [WB_DEPTH];

    // Shift the in-flight writers one stage forward; the WB entry drops off.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                sb[i] <= '0;
            end
        end else if (advance) begin
            sb[0] <= push_entry;
            for (int i = 1; i < WB_DEPTH; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    // Compare the ID sources against the tracked destinations.
    always_comb begin
        hazard = 1'b0;
`ifdef PIPE_CTRL_FWD_EN
        if (id_valid && sb[0].valid && sb[0].is_load &&
            (tag_hit(id_rs, id_rs_used, sb[0].rd) || tag_hit(id_rt, id_rt_used, sb[0].rd))) begin
            hazard = 1'b1;
        end
`else
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (id_valid && sb[i].valid &&
                (tag_hit(id_rs, id_rs_used, sb[i].rd) || tag_hit(id_rt, id_rt_used, sb[i].rd))) begin
                hazard = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stage-enable / flush controller with writeback hazard tracking,
// DMEM wait freeze, branch flush window and a saturating stall counter.
// Build option PIPE_CTRL_FWD_EN selects load-use-only hazards (forwarding).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | all stages advance
//   STALL   | hazard: hold IF/ID, bubble into EX, re-check every cycle
//   MEMWAIT | DMEM busy: everything frozen, resume_q holds where to return
//   FLUSH   | squash window after a taken branch, flush_cnt_q cycles left
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WB_DEPTH     = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_wb_en,
    input  logic [TAG_W-1:0] id_rs,
    input  logic [TAG_W-1:0] id_rt,
    input  logic [TAG_W-1:0] id_rd,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             wb_en,
    output logic             id_flush,
    output logic             ex_flush,
    output logic [15:0]      stall_cnt
);

    // The branch cycle itself is the first flush cycle.
    localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    state_t     resume_q, resume_d;
    state_t     cur;
    logic [7:0] flush_cnt_q, flush_cnt_d;
    logic       hazard;
    logic       mem_wait;
    sb_entry_t  push_entry;

    assign mem_wait = mem_req & ~mem_ready;
    assign cur      = (state_q == ST_MEMWAIT) ? resume_q : state_q;

    // Stalled or flushed cycles feed a bubble into EX.
    always_comb begin
        push_entry         = '0;
        push_entry.valid   = id_valid & id_wb_en & ~ex_flush;
        push_entry.rd      = id_rd;
        push_entry.is_load = id_is_load;
    end

    hazard_scoreboard #(
        .WB_DEPTH (WB_DEPTH)
    ) u_sb (
        .clock      (clock),
        .reset      (reset),
        .advance    (ex_en),
        .push_entry (push_entry),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .hazard     (hazard)
    );

    // Next-state and stage controls, highest-priority event first.
    always_comb begin
        if_en       = 1'b1;
        id_en       = 1'b1;
        ex_en       = 1'b1;
        wb_en       = 1'b1;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        state_d     = ST_RUN;
        resume_d    = resume_q;
        flush_cnt_d = flush_cnt_q;
        if (reset) begin
            if_en    = 1'b0;
            id_en    = 1'b0;
            ex_en    = 1'b0;
            wb_en    = 1'b0;
            id_flush = 1'b1;
            ex_flush = 1'b1;
        end else if (mem_wait) begin
            if_en    = 1'b0;
            id_en    = 1'b0;
            ex_en    = 1'b0;
            wb_en    = 1'b0;
            state_d  = ST_MEMWAIT;
            resume_d = cur;
        end else if (cur == ST_FLUSH) begin
            // Branches seen here belong to already-squashed instructions.
            id_flush = 1'b1;
            ex_flush = 1'b1;
            if (flush_cnt_q <= 8'd1) begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end else begin
                state_d     = ST_FLUSH;
                flush_cnt_d = flush_cnt_q - 8'd1;
            end
        end else if (ex_branch_taken) begin
            // Any concurrent hazard is on a squashed instruction and is dropped.
            id_flush = 1'b1;
            ex_flush = 1'b1;
            if (FLUSH_INIT != 8'd0) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FLUSH_INIT;
            end else begin
                flush_cnt_d = '0;
            end
        end else if (hazard) begin
            if_en    = 1'b0;
            id_en    = 1'b0;
            ex_flush = 1'b1;
            state_d  = ST_STALL;
        end
    end

    // Controller state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            resume_q    <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Count fetch-stalled cycles, sticking at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!if_en && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, with every
// cycle's expected controls queued by a behavioural model and compared by
// an independent monitor.
module tb_pipe_ctrl;

    localparam int WB_DEPTH     = 3;
    localparam int FLUSH_CYCLES = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid, id_wb_en, id_rs_used, id_rt_used, id_is_load;
    logic [5:0]  id_rs, id_rt, id_rd;
    logic        ex_branch_taken, mem_req, mem_ready;
    logic        if_en, id_en, ex_en, wb_en, id_flush, ex_flush;
    logic [15:0] stall_cnt;

    always #5 clock = ~clock;

    pipe_ctrl #(
        .WB_DEPTH     (WB_DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_wb_en        (id_wb_en),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_rs_used      (id_rs_used),
        .id_rt_used      (id_rt_used),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .if_en           (if_en),
        .id_en           (id_en),
        .ex_en           (ex_en),
        .wb_en           (wb_en),
        .id_flush        (id_flush),
        .ex_flush        (ex_flush),
        .stall_cnt       (stall_cnt)
    );

    typedef struct {
        bit rst, valid, wb, rsu, rtu, ld, br, mreq, mrdy;
        int rs, rt, rd;
    } stim_t;

    typedef struct {
        bit v;
        int rd;
        bit ld;
    } inflight_t;

    typedef struct {
        bit ife, ide, exe, wbe, idf, exf;
        int cnt;
    } exp_t;

    inflight_t pend[$];
    exp_t      exp_q[$];
    exp_t      mon_e;
    int        flush_left = 0;
    int        m_cnt = 0;
    int        vectors = 0;
    int        miscompares = 0;

    task automatic chk(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.valid = 0; s.wb = 0; s.rsu = 0; s.rtu = 0; s.ld = 0;
        s.br = 0; s.mreq = 0; s.mrdy = 0; s.rs = 0; s.rt = 0; s.rd = 0;
        return s;
    endfunction

    function automatic void clear_pend();
        inflight_t b;
        b.v = 0; b.rd = 0; b.ld = 0;
        pend.delete();
        for (int i = 0; i < WB_DEPTH; i++) pend.push_back(b);
    endfunction

    // Does the ID instruction read a register some in-flight writer has not yet written?
    function automatic bit model_hazard(input stim_t s);
        bit hit;
        if (!s.valid) return 0;
        foreach (pend[i]) begin
            hit = (s.rsu && s.rs != 0 && s.rs == pend[i].rd) ||
                  (s.rtu && s.rt != 0 && s.rt == pend[i].rd);
`ifdef PIPE_CTRL_FWD_EN
            if (i == 0 && pend[i].v && pend[i].ld && hit) return 1;
`else
            if (pend[i].v && hit) return 1;
`endif
        end
        return 0;
    endfunction

    // Drive one cycle of inputs, predict the controls, and let the model move on.
    task automatic apply(input stim_t s);
        exp_t      e;
        inflight_t nw;
        bit        frozen;
        @(negedge clock);
        reset           = s.rst;
        id_valid        = s.valid;
        id_wb_en        = s.wb;
        id_rs           = 6'(s.rs);
        id_rt           = 6'(s.rt);
        id_rd           = 6'(s.rd);
        id_rs_used      = s.rsu;
        id_rt_used      = s.rtu;
        id_is_load      = s.ld;
        ex_branch_taken = s.br;
        mem_req         = s.mreq;
        mem_ready       = s.mrdy;
        e.ife = 1; e.ide = 1; e.exe = 1; e.wbe = 1; e.idf = 0; e.exf = 0;
        if (s.rst) begin
            e.ife = 0; e.ide = 0; e.exe = 0; e.wbe = 0; e.idf = 1; e.exf = 1;
            e.cnt = 0;
            clear_pend();
            flush_left = 0;
            m_cnt = 0;
        end else begin
            e.cnt = m_cnt;
            nw.v = 0; nw.rd = 0; nw.ld = 0;
            frozen = s.mreq && !s.mrdy;
            if (frozen) begin
                e.ife = 0; e.ide = 0; e.exe = 0; e.wbe = 0;
            end else if (flush_left > 0) begin
                e.idf = 1; e.exf = 1;
                flush_left--;
            end else if (s.br) begin
                e.idf = 1; e.exf = 1;
                flush_left = FLUSH_CYCLES - 1;
            end else if (model_hazard(s)) begin
                e.ife = 0; e.ide = 0; e.exf = 1;
            end else if (s.valid && s.wb) begin
                nw.v = 1; nw.rd = s.rd; nw.ld = s.ld;
            end
            if (!frozen) begin
                pend.push_front(nw);
                void'(pend.pop_back());
            end
            if (!e.ife && m_cnt < 65535) m_cnt++;
        end
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compare every presented cycle against the queued prediction.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                vectors++;
                if (if_en !== mon_e.ife || id_en !== mon_e.ide || ex_en !== mon_e.exe ||
                    wb_en !== mon_e.wbe || id_flush !== mon_e.idf || ex_flush !== mon_e.exf ||
                    int'(stall_cnt) != mon_e.cnt) begin
                    miscompares++;
                    $display("FAIL ctrl t=%0t: got en=%b%b%b%b fl=%b%b cnt=%0d, want en=%b%b%b%b fl=%b%b cnt=%0d",
                             $time, if_en, id_en, ex_en, wb_en, id_flush, ex_flush, stall_cnt,
                             mon_e.ife, mon_e.ide, mon_e.exe, mon_e.wbe, mon_e.idf, mon_e.exf, mon_e.cnt);
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < WB_DEPTH + FLUSH_CYCLES; i++) apply(idle());
    endtask

    task automatic raw_seq(input bit ld, input int want, input string tag);
        stim_t s, b;
        int    c0, stalls;
        apply(idle());
        c0 = int'(stall_cnt);
        s = idle(); s.valid = 1; s.wb = 1; s.rd = 5; s.ld = ld;
        apply(s);
        b = idle(); b.valid = 1; b.wb = 1; b.rd = 6; b.rs = 5; b.rsu = 1;
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            apply(b);
            if (if_en) break;
            stalls++;
        end
        chk({tag, "_stall_cycles"}, stalls, want);
        chk({tag, "_stall_cnt_delta"}, int'(stall_cnt) - c0, want);
        drain();
    endtask

    initial begin
        stim_t s;
        int    nfl, nfrz, nif0;
        bit    flush_after;
        clear_pend();

        s = idle(); s.rst = 1;
        apply(s);
        apply(s);
        chk("reset_if_en", int'(if_en), 0);
        chk("reset_id_flush", int'(id_flush), 1);
        apply(idle());
        chk("post_reset_run", int'(if_en & id_en & ex_en & wb_en), 1);

        // Read-after-write on r5, load and non-load producers.
`ifdef PIPE_CTRL_FWD_EN
        raw_seq(1'b1, 1, "raw_load");
        raw_seq(1'b0, 0, "raw_alu");
`else
        raw_seq(1'b0, WB_DEPTH, "raw_alu");
        raw_seq(1'b1, WB_DEPTH, "raw_load");
`endif
        chk("stall_cnt_after_raw", int'(stall_cnt), m_cnt);

        // Single-cycle taken branch opens a FLUSH_CYCLES-long squash window.
        nfl = 0; nif0 = 0;
        s = idle(); s.br = 1;
        apply(s);
        if (id_flush && ex_flush) nfl++;
        if (!if_en) nif0++;
        for (int i = 0; i < 4; i++) begin
            apply(idle());
            if (id_flush && ex_flush) nfl++;
            if (!if_en) nif0++;
        end
        chk("branch_flush_cycles", nfl, FLUSH_CYCLES);
        chk("branch_if_en_low", nif0, 0);

        // DMEM wait landing on the last flush cycle.
        nfl = 0; nfrz = 0; flush_after = 0;
        s = idle(); s.br = 1;
        apply(s);
        if (id_flush) nfl++;
        s = idle(); s.mreq = 1; s.mrdy = 0;
        for (int i = 0; i < 4; i++) begin
            apply(s);
            if (!if_en && !id_en && !ex_en && !wb_en) nfrz++;
        end
        s.mrdy = 1;
        apply(s);
        flush_after = id_flush && ex_flush && if_en;
        if (id_flush) nfl++;
        for (int i = 0; i < 3; i++) begin
            apply(idle());
            if (id_flush) nfl++;
        end
        chk("memwait_frozen_cycles", nfrz, 4);
        chk("memwait_resume_flush", int'(flush_after), 1);
        chk("memwait_total_flush", nfl, FLUSH_CYCLES);

        // Branch and hazard together: flush wins, no stall.
        s = idle(); s.valid = 1; s.wb = 1; s.rd = 5; s.ld = 1;
        apply(s);
        s = idle(); s.valid = 1; s.rs = 5; s.rsu = 1; s.br = 1;
        apply(s);
        chk("br_hazard_if_en", int'(if_en), 1);
        chk("br_hazard_flush", int'(id_flush & ex_flush), 1);
        drain();

        // Register zero never conflicts.
        s = idle(); s.valid = 1; s.wb = 1; s.rd = 0; s.ld = 1;
        apply(s);
        s = idle(); s.valid = 1; s.rs = 0; s.rt = 0; s.rsu = 1; s.rtu = 1;
        apply(s);
        chk("zero_tag_no_stall", int'(if_en), 1);
        drain();

        // Reset in the middle of a DMEM wait.
        s = idle(); s.valid = 1; s.wb = 1; s.rd = 5; s.ld = 1;
        apply(s);
        s = idle(); s.mreq = 1;
        for (int i = 0; i < 3; i++) apply(s);
        s = idle(); s.rst = 1;
        apply(s);
        chk("rst_memwait_cnt", int'(stall_cnt), 0);
        s = idle(); s.valid = 1; s.rs = 5; s.rsu = 1;
        apply(s);
        chk("rst_sb_empty", int'(if_en), 1);
        chk("rst_cnt_after", int'(stall_cnt), 0);

        // Reset in the middle of a flush window.
        s = idle(); s.br = 1;
        apply(s);
        s = idle(); s.rst = 1;
        apply(s);
        apply(idle());
        chk("rst_flush_abandoned", int'(id_flush), 0);
        drain();

        // Saturate the stall counter and stall once more.
        s = idle(); s.mreq = 1;
        for (int i = 0; i < 65540; i++) apply(s);
        chk("stall_cnt_sat", int'(stall_cnt), 65535);
        s = idle(); s.valid = 1; s.wb = 1; s.rd = 5; s.ld = 1;
        apply(s);
        s = idle(); s.valid = 1; s.rs = 5; s.rsu = 1;
        apply(s);
        chk("sat_stall_if_en", int'(if_en), 0);
        apply(idle());
        chk("stall_cnt_held", int'(stall_cnt), 65535);
        s = idle(); s.rst = 1;
        apply(s);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rst   = ($urandom_range(0, 199) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.wb    = $urandom_range(0, 1) == 1;
            s.rsu   = $urandom_range(0, 1) == 1;
            s.rtu   = $urandom_range(0, 1) == 1;
            s.ld    = $urandom_range(0, 1) == 1;
            s.br    = ($urandom_range(0, 15) == 0);
            s.mreq  = ($urandom_range(0, 5) == 0);
            s.mrdy  = $urandom_range(0, 1) == 1;
            s.rs    = int'($urandom_range(0, 7));
            s.rt    = int'($urandom_range(0, 7));
            s.rd    = int'($urandom_range(0, 7));
            apply(s);
        end
        apply(idle());

        repeat (3) @(negedge clock);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
